comparator_cfg_loader: RTL and testbench

//  Sequences the write-port of the comparator's result RAM: on a start request it fills all addresses
//  0..VECTOR_WIDTH with the threshold table T[c] = floor(c * M), M = fixed-point threshold multiplier.

---
 rtl/comparator_cfg_loader.sv | 132 +++++++++++++
 tb/tb_comparator_cfg_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : comparator_cfg_loader
// Description : Sequences the write port of the comparator's result RAM.
//               A start request fills addresses 0..VECTOR_WIDTH with the
//               threshold table T[c] = floor(c * M). M is an unsigned
//               Q(4.FRAC_WIDTH) multiplier. The table is built with one
//               addition per entry, so no multiplier is used. Upstream
//               popcount traffic is held off while the table loads, and a
//               flag reports when the table is valid.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               i_Start, i_Mult   load request and multiplier (latched on start)
//               o_Busy, o_Done    load in progress, 1-cycle completion pulse
//               o_CfgValid        table fully loaded
//               o_Ready           upstream may issue lookups
//               o_BRAM_*          RAM address, data, enable, write enable
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_cfg_loader #(
  parameter int VECTOR_WIDTH = 920,
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
  parameter int FRAC_WIDTH   = 8,
  parameter int MULT_WIDTH   = FRAC_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Start,
  input  logic [MULT_WIDTH-1:0] i_Mult,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_CfgValid,
  output logic                  o_Ready,
  output logic [CNT_WIDTH-1:0]  o_BRAM_Addr,
  output logic [CNT_WIDTH:0]    o_BRAM_Din,
  output logic                  o_BRAM_En,
  output logic                  o_BRAM_WrEn
);

  // Wide enough for (VECTOR_WIDTH+1) * max multiplier, so it never wraps.
  localparam int ACC_WIDTH = CNT_WIDTH + MULT_WIDTH + 1;
  localparam int DIN_WIDTH = CNT_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] c_LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);
  localparam logic [ACC_WIDTH-1:0] c_DIN_MAX   = ACC_WIDTH'((64'd1 << DIN_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [MULT_WIDTH-1:0] r_mult;

  logic [ACC_WIDTH-1:0]  w_int;
  logic [DIN_WIDTH-1:0]  w_sat;

  // Integer part of the running product c*M. Large multipliers would exceed
  // the RAM data width, so the value is clamped at the data-width maximum
  // and never wraps.
  assign w_int = r_acc >> FRAC_WIDTH;
  assign w_sat = (w_int > c_DIN_MAX) ? {DIN_WIDTH{1'b1}} : w_int[DIN_WIDTH-1:0];

  // Derived from registered flags only, so it does not glitch on i_Start.
  assign o_Ready = o_CfgValid & ~o_Busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mult      <= '0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_CfgValid  <= 1'b0;
      o_BRAM_Addr <= '0;
      o_BRAM_Din  <= '0;
      o_BRAM_En   <= 1'b0;
      o_BRAM_WrEn <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          o_BRAM_WrEn <= 1'b0;
          if (i_Start) begin
            r_state    <= ST_LOAD;
            r_mult     <= i_Mult;
            r_cnt      <= '0;
            r_acc      <= '0;
            o_CfgValid <= 1'b0;
            o_Busy     <= 1'b1;
            o_BRAM_En  <= 1'b0;
          end else begin
            // The read path is only enabled once a complete table exists.
            o_BRAM_En <= o_CfgValid;
          end
        end

        ST_LOAD: begin
          o_BRAM_En   <= 1'b1;
          o_BRAM_WrEn <= 1'b1;
          o_BRAM_Addr <= r_cnt;
          o_BRAM_Din  <= w_sat;
          r_cnt       <= r_cnt + 1'b1;
          r_acc       <= r_acc + ACC_WIDTH'(r_mult);
          if (r_cnt == c_LAST_ADDR) begin
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          o_BRAM_WrEn <= 1'b0;
          o_BRAM_En   <= 1'b1;
          o_Done      <= 1'b1;
          o_CfgValid  <= 1'b1;
          o_Busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: begin
          o_BRAM_WrEn <= 1'b0;
          o_Busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comparator_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_cfg_loader
// Description : Self-checking bench for comparator_cfg_loader. Builds full
//               tables for several multipliers and probes them against
//               hand-computed values. Also covers ignored restarts,
//               asynchronous reset in idle and mid-load, and reload gating
//               of o_Ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_cfg_loader;

  localparam int VW = 920;

  logic        clk;
  logic        rst;
  logic        i_Start;
  logic [11:0] i_Mult;
  logic        o_Busy;
  logic        o_Done;
  logic        o_CfgValid;
  logic        o_Ready;
  logic [9:0]  o_BRAM_Addr;
  logic [10:0] o_BRAM_Din;
  logic        o_BRAM_En;
  logic        o_BRAM_WrEn;

  comparator_cfg_loader dut (
    .clk         (clk),
    .rst         (rst),
    .i_Start     (i_Start),
    .i_Mult      (i_Mult),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_CfgValid  (o_CfgValid),
    .o_Ready     (o_Ready),
    .o_BRAM_Addr (o_BRAM_Addr),
    .o_BRAM_Din  (o_BRAM_Din),
    .o_BRAM_En   (o_BRAM_En),
    .o_BRAM_WrEn (o_BRAM_WrEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mem [0:VW];

  typedef struct {
    int mult;
    int addr;
    int din;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input int c, input int m);
    int v;
    v = (c * m) / 256;
    return (v > 2047) ? 2047 : v;
  endfunction

  // Runs one full load with multiplier m. Every write is checked against the
  // reference formula, and its data is captured into mem for table probes.
  // With extra_starts set, start pulses are also driven at cycles 5 and 921.
  task automatic do_load(input int m, input bit extra_starts);
    int next_addr;
    int bad;
    int first_bad;
    int dones;
    int done_cyc;
    int ready_early;
    int cfg_early;
    int busy_low;
    next_addr   = 0;
    bad         = 0;
    first_bad   = -1;
    dones       = 0;
    done_cyc    = 0;
    ready_early = 0;
    cfg_early   = 0;
    busy_low    = 0;
    for (int i = 0; i <= VW; i++) mem[i] = -1;

    @(negedge clk);
    i_Mult  = 12'(m);
    i_Start = 1'b1;
    @(posedge clk);
    #1;
    i_Start = 1'b0;
    i_Mult  = ~12'(m);   // must have no effect after the start edge
    check("start_cfg_drop", int'(o_CfgValid), 0);
    check("start_busy", int'(o_Busy), 1);

    for (int cyc = 1; cyc <= 1000; cyc++) begin
      i_Start = extra_starts && (cyc == 5 || cyc == 921);
      @(posedge clk);
      #1;
      i_Start = 1'b0;
      if (o_BRAM_WrEn) begin
        if (int'(o_BRAM_Addr) != next_addr || int'(o_BRAM_Din) != model(next_addr, m)
            || cyc != next_addr + 1) begin
          bad++;
          if (first_bad < 0) first_bad = next_addr;
        end
        if (next_addr <= VW) mem[o_BRAM_Addr] = int'(o_BRAM_Din);
        next_addr++;
      end
      if (dones == 0 && !o_Done) begin
        if (o_Ready)    ready_early++;
        if (o_CfgValid) cfg_early++;
        if (!o_Busy)    busy_low++;
      end
      if (o_Done) begin
        dones++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc == done_cyc + 3) break;
    end

    if (bad != 0) $display("  first bad write index %0d (m=%0d)", first_bad, m);
    check("write_errors", bad, 0);
    check("write_count", next_addr, VW + 1);
    check("done_count", dones, 1);
    check("done_cycle", done_cyc, VW + 2);
    check("ready_during_load", ready_early, 0);
    check("cfg_during_load", cfg_early, 0);
    check("busy_low_during_load", busy_low, 0);
    check("post_cfg_valid", int'(o_CfgValid), 1);
    check("post_ready", int'(o_Ready), 1);
    check("post_en", int'(o_BRAM_En), 1);
    check("post_wren", int'(o_BRAM_WrEn), 0);
  endtask

  int loaded_m;
  int found;

  initial begin
    vecs[0]  = '{384,    0,    0};
    vecs[1]  = '{384,    1,    1};
    vecs[2]  = '{384,    2,    3};
    vecs[3]  = '{384,    3,    4};
    vecs[4]  = '{384,  101,  151};
    vecs[5]  = '{384,  920, 1380};
    vecs[6]  = '{1024, 511, 2044};
    vecs[7]  = '{1024, 512, 2047};
    vecs[8]  = '{1024, 920, 2047};
    vecs[9]  = '{512,    7,   14};
    vecs[10] = '{512,  920, 1840};
    vecs[11] = '{0,    920,    0};
    vecs[12] = '{4095,   1,   15};
    vecs[13] = '{4095, 920, 2047};

    rst     = 1'b1;
    i_Start = 1'b0;
    i_Mult  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({o_Busy, o_Done, o_CfgValid, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn}), 0);
    check("reset_ready", int'(o_Ready), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cfg_valid", int'(o_CfgValid), 0);
    check("idle_en", int'(o_BRAM_En), 0);

    // Table probes. A new load is run whenever the multiplier changes. The
    // 512 load follows a valid table, so it also exercises a reload.
    loaded_m = -1;
    foreach (vecs[k]) begin
      if (vecs[k].mult != loaded_m) begin
        do_load(vecs[k].mult, 1'b0);
        loaded_m = vecs[k].mult;
      end
      check($sformatf("table_m%0d_a%0d", vecs[k].mult, vecs[k].addr),
            mem[vecs[k].addr], vecs[k].din);
    end

    // Start pulses during LOAD are ignored: still exactly one clean pass.
    do_load(384, 1'b1);

    // Asynchronous reset mid-cycle while idle with a valid table.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          int'({o_Busy, o_Done, o_CfgValid, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn}), 0);
    check("async_reset_ready", int'(o_Ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset at address 400 of a load.
    @(negedge clk);
    i_Mult  = 12'd384;
    i_Start = 1'b1;
    @(posedge clk);
    #1;
    i_Start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(posedge clk);
      #1;
      if (o_BRAM_WrEn && o_BRAM_Addr == 10'd400) begin
        found = 1;
        break;
      end
    end
    check("reached_addr_400", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midload_rst_wren", int'(o_BRAM_WrEn), 0);
    check("midload_rst_busy", int'(o_Busy), 0);
    check("midload_rst_cfg", int'(o_CfgValid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("after_rst_no_resume", int'(o_BRAM_WrEn), 0);
    check("after_rst_cfg", int'(o_CfgValid), 0);
    do_load(384, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
